// File: rtl/op_sequencer_pkg.sv
// Shared types and constants for the op_sequencer command scheduler.
package seq_pkg;

    localparam int unsigned REG_W = 3;
    localparam int unsigned OP_W  = 3;
    localparam logic [REG_W-1:0] NULL_SEL = 3'b000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ISSUE,
        S_SEL1,
        S_GAP1,
        S_SEL2,
        S_GAP2,
        S_OPC,
        S_WAIT,
        S_WB
    } seq_state_t;

    typedef struct packed {
        logic [REG_W-1:0] dst;
        logic [REG_W-1:0] op1;
        logic [REG_W-1:0] op2;
        logic [OP_W-1:0]  opcode;
    } cmd_t;

    // Zero in any field means "no selection", so such a command cannot run.
    function automatic logic cmd_ok(cmd_t c);
        return (c.dst != NULL_SEL) && (c.op1 != NULL_SEL) &&
               (c.op2 != NULL_SEL) && (c.opcode != NULL_SEL);
    endfunction

endpackage

// File: rtl/op_sequencer_if.sv
// Command, read-FSM and writeback signals of op_sequencer; slave = sequencer side.
interface op_sequencer_if;
    import seq_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [REG_W-1:0] cmd_dst;
    logic [REG_W-1:0] cmd_op1;
    logic [REG_W-1:0] cmd_op2;
    logic [OP_W-1:0]  cmd_opcode;
    logic             r_en;
    logic [REG_W-1:0] reg_num;
    logic [OP_W-1:0]  opcode;
    logic             result_ready;
    logic             wr_en;
    logic [REG_W-1:0] wr_sel;
    logic             busy;
    logic             done;
    logic             err;
    logic [7:0]       ops_done_cnt;

    modport slave (
        input  cmd_valid, cmd_dst, cmd_op1, cmd_op2, cmd_opcode, result_ready,
        output cmd_ready, r_en, reg_num, opcode, wr_en, wr_sel, busy, done, err,
               ops_done_cnt
    );

    modport master (
        output cmd_valid, cmd_dst, cmd_op1, cmd_op2, cmd_opcode, result_ready,
        input  cmd_ready, r_en, reg_num, opcode, wr_en, wr_sel, busy, done, err,
               ops_done_cnt
    );

endinterface

// File: rtl/op_sequencer_cmd_fifo.sv
// Command FIFO: synchronous push/pop, wrap-bit pointers to tell full from empty.
module cmd_fifo
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  cmd_t                   data_i,
    output cmd_t                   data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    cmd_t        mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/op_sequencer.sv
// Replays queued {dst, op1, op2, opcode} commands onto the read FSM, then writes back.
// Optional SEQ_STATS_EN: saturating 8-bit count of completed ops on ops_done_cnt.
module op_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         nrst,
    op_sequencer_if.slave bus
);

    localparam int unsigned TW = $clog2(TIMEOUT);

    seq_state_t            state_q, state_d;
    cmd_t                  cur_q, cur_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  err_inv_q, err_inv_d;

    cmd_t                  cmd_in, fifo_head;
    logic                  fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  accept, push, pop;

    logic                  r_en, wr_en, done, tmo_err;
    logic [REG_W-1:0]      reg_num, wr_sel;
    logic [OP_W-1:0]       opcode;

    assign cmd_in = '{dst: bus.cmd_dst, op1: bus.cmd_op1,
                      op2: bus.cmd_op2, opcode: bus.cmd_opcode};

    // Invalid commands are still accepted so the source never stalls on them.
    assign accept    = bus.cmd_valid && !fifo_full;
    assign push      = accept && cmd_ok(cmd_in);
    assign err_inv_d = accept && !cmd_ok(cmd_in);
    assign pop       = (state_q == S_IDLE) && !fifo_empty;
    assign cur_d     = pop ? fifo_head : cur_q;

    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (cmd_in),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        tmo_err = 1'b0;
        r_en    = 1'b0;
        reg_num = NULL_SEL;
        opcode  = NULL_SEL;
        wr_en   = 1'b0;
        wr_sel  = NULL_SEL;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE:  if (!fifo_empty) state_d = S_ISSUE;
            S_ISSUE: begin
                r_en    = 1'b1;
                state_d = S_SEL1;
            end
            S_SEL1: begin
                reg_num = cur_q.op1;
                state_d = S_GAP1;
            end
            S_GAP1:  state_d = S_SEL2;
            S_SEL2: begin
                reg_num = cur_q.op2;
                state_d = S_GAP2;
            end
            S_GAP2:  state_d = S_OPC;
            S_OPC: begin
                opcode  = cur_q.opcode;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (bus.result_ready) begin
                    state_d = S_WB;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    tmo_err = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                wr_en   = 1'b1;
                wr_sel  = cur_q.dst;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            tmo_q     <= '0;
            err_inv_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            tmo_q     <= tmo_d;
            err_inv_q <= err_inv_d;
        end
    end

    assign bus.cmd_ready = !fifo_full;
    assign bus.r_en      = r_en;
    assign bus.reg_num   = reg_num;
    assign bus.opcode    = opcode;
    assign bus.wr_en     = wr_en;
    assign bus.wr_sel    = wr_sel;
    assign bus.done      = done;
    assign bus.err       = err_inv_q | tmo_err;
    assign bus.busy      = (state_q != S_IDLE) || (fifo_count != '0);

`ifdef SEQ_STATS_EN
    logic [7:0] ops_cnt_q, ops_cnt_d;

    assign ops_cnt_d = (done && ops_cnt_q != 8'hFF) ? ops_cnt_q + 1'b1 : ops_cnt_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) ops_cnt_q <= '0;
        else       ops_cnt_q <= ops_cnt_d;
    end

    assign bus.ops_done_cnt = ops_cnt_q;
`else
    assign bus.ops_done_cnt = '0;
`endif

endmodule
